// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - QSPI flash read responder (03h single, 6Bh quad-output) fed from a byte store
module qspi_flash_responder #(
    parameter int DUMMY_CLKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic [3:0]  spi_io_in,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        cmd_err
);
    localparam logic [7:0] CMD_QUAD   = 8'h6B;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CLKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE} state_t;
    state_t state, state_n;

    logic [1:0]  sclk_sync, cs_sync, di_sync;
    logic        sclk_q, cs_q;
    logic        cs_high, cs_fall, sclk_rise, sclk_fall, di;
    logic [4:0]  bit_cnt;
    logic [6:0]  cmd_sr;
    logic [7:0]  cmd_byte;
    logic        cmd_ok, quad;
    logic [23:0] addr_sr, addr_next;
    logic        rd_pend;
    logic [7:0]  pref_buf, cur_byte, src_byte;
    logic [2:0]  unit_pos;
    logic        unit_last;
    logic        unused_io;

    assign unused_io = ^spi_io_in[3:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            di_sync   <= 2'b00;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            di_sync   <= {di_sync[0], spi_io_in[0]};
            sclk_q    <= sclk_sync[1];
            cs_q      <= cs_sync[1];
        end
    end

    // A CS release in the same cycle as an SCLK edge suppresses the edge.
    assign cs_high   = cs_sync[1];
    assign cs_fall   = cs_q & ~cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_q & ~cs_high;
    assign sclk_fall = ~sclk_sync[1] & sclk_q & ~cs_high;
    assign di        = di_sync[1];

    assign cmd_byte  = {cmd_sr, di};
    assign cmd_ok    = (cmd_byte == CMD_QUAD) || (cmd_byte == CMD_READ);
    assign addr_next = {addr_sr[22:0], di};
    assign unit_last = quad ? (unit_pos == 3'd1) : (unit_pos == 3'd7);
    assign src_byte  = (unit_pos == 3'd0) ? pref_buf : cur_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = (state != S_IDLE);
        case (state)
            S_IDLE:  if (cs_fall) state_n = S_CMD;
            S_CMD:   if (sclk_rise && bit_cnt == 5'd7) state_n = cmd_ok ? S_ADDR : S_IGNORE;
            S_ADDR:  if (sclk_rise && bit_cnt == 5'd23) state_n = quad ? S_DUMMY : S_DATA;
            S_DUMMY: if (sclk_rise && bit_cnt == DUMMY_LAST) state_n = S_DATA;
            default: state_n = state;
        endcase
        if (cs_high) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            quad       <= 1'b0;
            addr_sr    <= '0;
            rd_pend    <= 1'b0;
            pref_buf   <= '0;
            cur_byte   <= '0;
            unit_pos   <= '0;
            spi_io_out <= '0;
            spi_io_oe  <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            cmd_err <= 1'b0;
            rd_pend <= mem_rd;
            if (rd_pend) pref_buf <= mem_rdata;
            if (cs_high || state == S_IDLE) begin
                bit_cnt    <= '0;
                unit_pos   <= '0;
                spi_io_oe  <= '0;
                spi_io_out <= '0;
            end else begin
                case (state)
                    S_CMD: if (sclk_rise) begin
                        cmd_sr  <= cmd_byte[6:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            quad    <= (cmd_byte == CMD_QUAD);
                            cmd_err <= ~cmd_ok;
                        end
                    end
                    S_ADDR: if (sclk_rise) begin
                        addr_sr <= addr_next;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            if (!quad) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= addr_next;
                            end
                        end
                    end
                    S_DUMMY: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == DUMMY_LAST) begin
                            bit_cnt  <= '0;
                            mem_rd   <= 1'b1;
                            mem_addr <= addr_sr;
                        end
                    end
                    // Launching the first unit of a byte consumes the buffer and prefetches the next byte.
                    S_DATA: if (sclk_fall) begin
                        spi_io_oe  <= quad ? 4'hF : 4'h2;
                        spi_io_out <= quad ? src_byte[7:4] : {2'b00, src_byte[7], 1'b0};
                        cur_byte   <= quad ? {src_byte[3:0], 4'h0} : {src_byte[6:0], 1'b0};
                        unit_pos   <= unit_last ? 3'd0 : unit_pos + 3'd1;
                        if (unit_pos == 3'd0) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + 24'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/qspi_flash_responder.md
QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

Interface
REQ-001 Parameter DUMMY_CLKS, default 8, SHALL set the number of dummy SCLK cycles between address and data for command 6Bh.
REQ-002 clk  input  1  system clock, single clock domain; SCLK half-period SHALL be at least 5 clk cycles.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 spi_clk  input  1  SPI clock from the flash initiator, asynchronous to clk.
REQ-005 spi_cs_n  input  1  chip select, active low.
REQ-006 spi_io_in  input  4  IO[3:0] pad inputs; IO0 = DI.
REQ-007 spi_io_out  output  4  IO[3:0] pad output values.
REQ-008 spi_io_oe  output  4  per-pin output enable, 1 = drive.
REQ-009 mem_addr  output  24  byte address to the backing store.
REQ-010 mem_rd  output  1  one-cycle read strobe; mem_rdata SHALL be valid the cycle after.
REQ-011 mem_rdata  input  8  byte from the backing store.
REQ-012 busy  output  1  high while CS is asserted and a transaction is in progress.
REQ-013 cmd_err  output  1  one-cycle pulse on receipt of an unsupported command byte.

Function
REQ-014 spi_clk, spi_cs_n and spi_io_in[0] SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected from the synchronized value.
REQ-015 States SHALL be IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-016 IDLE -> CMD on synchronized CS falling; the bit counter clears.
REQ-017 Input bits SHALL be sampled on SCLK rising edges, MSB first.
REQ-018 CMD: after 8 bits, 6Bh or 03h -> ADDR; any other byte -> IGNORE, with a cmd_err pulse.
REQ-019 ADDR: 24 bits MSB first SHALL be shifted into the address register.
REQ-020 After address: 6Bh -> DUMMY; 03h -> DATA directly.
REQ-021 DUMMY: count DUMMY_CLKS rising edges, then -> DATA.
REQ-022 DATA output changes SHALL occur only on detected SCLK falling edges, within 2 clk cycles of detection.
REQ-023 6Bh data: spi_io_oe = 1111; each byte is driven high nibble first, then low nibble, on IO[3:0].
REQ-024 03h data: spi_io_oe = 0010; each byte is driven MSB first on IO1 only.
REQ-025 First data: driven on the first SCLK falling edge after the last address bit (03h) or the last dummy bit (6Bh).
REQ-026 Fetch: mem_rd SHALL pulse with mem_addr = start address on entry to the last address/dummy bit.
REQ-027 Prefetch: mem_rd for address+1 SHALL pulse when the first nibble/bit of the current byte is launched.
REQ-028 The prefetched byte SHALL be held in a 1-byte buffer until the current byte is exhausted.
REQ-029 The address SHALL increment by 1 per byte and wrap from FFFFFFh to 000000h.
REQ-030 DATA SHALL continue indefinitely while CS stays low.
REQ-031 SCLK may pause high or low for any duration; no output change occurs without an SCLK falling edge.
REQ-032 IGNORE: no outputs driven, no memory reads, until CS deasserts.
REQ-033 Synchronized CS high in any state -> IDLE next cycle, with spi_io_oe = 0000, busy = 0, and partial command/address discarded.
REQ-034 busy = 1 in CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-035 When CS rises and an SCLK edge are detected in the same cycle, CS wins and the edge is ignored.

Reset
REQ-036 On rst high, asynchronously: state = IDLE, spi_io_out = 0000, spi_io_oe = 0000, mem_addr = 000000h, mem_rd = 0, busy = 0, cmd_err = 0, synchronizers set to CS high and SCLK low.
REQ-037 rst mid-transaction SHALL abort it; after release the block SHALL wait for a fresh CS falling edge.

Verification
REQ-038 Quad read: 6Bh, address 000010h, 8 dummy clocks, memory[10h..12h] = A5h, 3Ch, 7Eh -> IO nibbles A,5,3,C,7,E with oe = 1111 from the first post-dummy falling edge; mem_addr sequence 10h, 11h, 12h, 13h.
REQ-039 Single read: 03h, address 000000h, memory[0] = 81h -> IO1 bits 1,0,0,0,0,0,0,1 with oe = 0010.
REQ-040 Wrap: 6Bh at FFFFFFh, read 2 bytes -> second byte from 000000h.
REQ-041 Bad command 9Fh -> one cmd_err pulse, oe stays 0000 and mem_rd stays 0 for 64 further clocks; CS high then 6Bh transaction responds normally.
REQ-042 CS deasserted after 12 address bits -> IDLE, oe = 0000, busy = 0; next 6Bh transaction decodes its full fresh address.
REQ-043 Pause: SCLK held low for 200 clk mid-data -> IO stable throughout; resumes with the correct next nibble.
REQ-044 Async rst pulse mid-DATA -> all outputs at reset values within the same cycle, no mem_rd afterward until a new command.
